// File: rtl/mult_share_ctrl.sv
// Round-robin sequencer sharing one combinational N x M multiplier between two
// requesters; waits SETTLE cycles for the product, then returns it tagged by ID.
module mult_share_ctrl #(
    parameter int N      = 4,
    parameter int M      = 5,
    parameter int SETTLE = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [N-1:0]   req0_a,
    input  logic [M-1:0]   req0_b,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [N-1:0]   req1_a,
    input  logic [M-1:0]   req1_b,
    output logic [N-1:0]   mult_a,
    output logic [M-1:0]   mult_b,
    input  logic [N+M-1:0] mult_prod,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [N+M-1:0] rsp_prod,
    output logic           rsp_id,
    output logic           busy
);

    localparam int CW = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             ptr_reg, ptr_next;
    logic             gid_reg, gid_next;
    logic [N-1:0]     mult_a_reg, mult_a_next;
    logic [M-1:0]     mult_b_reg, mult_b_next;
    logic             rsp_valid_reg, rsp_valid_next;
    logic [N+M-1:0]   rsp_prod_reg, rsp_prod_next;
    logic             rsp_id_reg, rsp_id_next;

    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [N-1:0]     req_a_arr [2];
    logic [M-1:0]     req_b_arr [2];
    logic             grant_vld;
    logic             grant_id;
    logic             contest;

    assign req_valid    = {req1_valid, req0_valid};
    assign req_a_arr[0] = req0_a;
    assign req_a_arr[1] = req1_a;
    assign req_b_arr[0] = req0_b;
    assign req_b_arr[1] = req1_b;

    // Pointer only breaks ties; a lone requester is granted regardless of it.
    assign contest   = &req_valid;
    assign grant_vld = |req_valid;
    assign grant_id  = contest ? ptr_reg : req_valid[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready[gi] = rst_n && (state_reg == S_IDLE) && grant_vld
                                   && (grant_id == 1'(gi));
        end
    endgenerate

    assign req0_ready = req_ready[0];
    assign req1_ready = req_ready[1];

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        ptr_next       = ptr_reg;
        gid_next       = gid_reg;
        mult_a_next    = mult_a_reg;
        mult_b_next    = mult_b_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_prod_next  = rsp_prod_reg;
        rsp_id_next    = rsp_id_reg;
        case (state_reg)
            S_IDLE: begin
                if (grant_vld) begin
                    mult_a_next = req_a_arr[grant_id];
                    mult_b_next = req_b_arr[grant_id];
                    gid_next    = grant_id;
                    cnt_next    = CW'(SETTLE - 1);
                    state_next  = S_SETTLE;
                    if (contest) begin
                        ptr_next = ~ptr_reg;
                    end
                end
            end
            S_SETTLE: begin
                // Operands were applied on the accept edge; product is stable now.
                if (cnt_reg == '0) begin
                    rsp_prod_next  = mult_prod;
                    rsp_id_next    = gid_reg;
                    rsp_valid_next = 1'b1;
                    state_next     = S_RESP;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    state_next     = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            ptr_reg       <= 1'b0;
            gid_reg       <= 1'b0;
            mult_a_reg    <= '0;
            mult_b_reg    <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_prod_reg  <= '0;
            rsp_id_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            ptr_reg       <= ptr_next;
            gid_reg       <= gid_next;
            mult_a_reg    <= mult_a_next;
            mult_b_reg    <= mult_b_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_prod_reg  <= rsp_prod_next;
            rsp_id_reg    <= rsp_id_next;
        end
    end

    assign mult_a    = mult_a_reg;
    assign mult_b    = mult_b_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_prod  = rsp_prod_reg;
    assign rsp_id    = rsp_id_reg;
    assign busy      = (state_reg != S_IDLE);

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Bench for mult_share_ctrl: directed scenarios plus random traffic checked
// against a transaction-level model of arbitration, latency and products.
module tb_mult_share_ctrl;

    localparam int N  = 4;
    localparam int M  = 5;
    localparam int ST = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic           req0_valid, req0_ready, req1_valid, req1_ready;
    logic [N-1:0]   req0_a, req1_a, mult_a;
    logic [M-1:0]   req0_b, req1_b, mult_b;
    logic [N+M-1:0] mult_prod, rsp_prod;
    logic           rsp_valid, rsp_ready, rsp_id, busy;

    // External array multiplier stand-in
    assign mult_prod = {{M{1'b0}}, mult_a} * {{N{1'b0}}, mult_b};

    mult_share_ctrl #(.N(N), .M(M), .SETTLE(ST)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .mult_a(mult_a), .mult_b(mult_b), .mult_prod(mult_prod),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_prod(rsp_prod),
        .rsp_id(rsp_id), .busy(busy)
    );

    logic           s1_rst_n;
    logic           s1_req0_valid, s1_req0_ready, s1_req1_valid, s1_req1_ready;
    logic [N-1:0]   s1_req0_a, s1_req1_a, s1_mult_a;
    logic [M-1:0]   s1_req0_b, s1_req1_b, s1_mult_b;
    logic [N+M-1:0] s1_mult_prod, s1_rsp_prod;
    logic           s1_rsp_valid, s1_rsp_ready, s1_rsp_id, s1_busy;

    assign s1_mult_prod = {{M{1'b0}}, s1_mult_a} * {{N{1'b0}}, s1_mult_b};

    mult_share_ctrl #(.N(N), .M(M), .SETTLE(1)) dut_s1 (
        .clk(clk), .rst_n(s1_rst_n),
        .req0_valid(s1_req0_valid), .req0_ready(s1_req0_ready), .req0_a(s1_req0_a), .req0_b(s1_req0_b),
        .req1_valid(s1_req1_valid), .req1_ready(s1_req1_ready), .req1_a(s1_req1_a), .req1_b(s1_req1_b),
        .mult_a(s1_mult_a), .mult_b(s1_mult_b), .mult_prod(s1_mult_prod),
        .rsp_valid(s1_rsp_valid), .rsp_ready(s1_rsp_ready), .rsp_prod(s1_rsp_prod),
        .rsp_id(s1_rsp_id), .busy(s1_busy)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Transaction-level model state
    bit             outstanding = 1'b0;
    int             acc_cyc = 0;
    bit             model_ptr = 1'b0;
    bit             exp_id;
    logic [N-1:0]   exp_ma;
    logic [M-1:0]   exp_mb;
    logic [N+M-1:0] exp_prod;
    bit             auto_drop = 1'b1;
    int             n_rsp = 0;
    int             id_log[$];
    int             prod_log[$];

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Evaluate one cycle against the model, then advance through the clock edge.
    task automatic step();
        bit both, g_vld, g_id, drop0, drop1;
        drop0 = 1'b0;
        drop1 = 1'b0;
        #1;
        if (!outstanding) begin
            check_val("idle_busy", int'(busy), 0);
            check_val("idle_rsp_valid", int'(rsp_valid), 0);
            both  = req0_valid && req1_valid;
            g_vld = (req0_valid || req1_valid) && rst_n;
            g_id  = both ? model_ptr : req1_valid;
            check_val("req0_ready", int'(req0_ready), int'(g_vld && !g_id));
            check_val("req1_ready", int'(req1_ready), int'(g_vld && g_id));
            if (g_vld) begin
                outstanding = 1'b1;
                acc_cyc     = cyc;
                exp_id      = g_id;
                exp_ma      = g_id ? req1_a : req0_a;
                exp_mb      = g_id ? req1_b : req0_b;
                exp_prod    = (N+M)'(exp_ma) * (N+M)'(exp_mb);
                if (both) model_ptr = ~model_ptr;
                if (auto_drop) begin
                    drop0 = !g_id;
                    drop1 = g_id;
                end
            end
        end else begin
            check_val("busy_req0_ready", int'(req0_ready), 0);
            check_val("busy_req1_ready", int'(req1_ready), 0);
            check_val("busy", int'(busy), 1);
            check_val("mult_a_hold", int'(mult_a), int'(exp_ma));
            check_val("mult_b_hold", int'(mult_b), int'(exp_mb));
            if (cyc <= acc_cyc + ST) begin
                check_val("settle_rsp_valid", int'(rsp_valid), 0);
            end else begin
                check_val("rsp_valid", int'(rsp_valid), 1);
                check_val("rsp_prod", int'(rsp_prod), int'(exp_prod));
                check_val("rsp_id", int'(rsp_id), int'(exp_id));
                if (rsp_ready) begin
                    outstanding = 1'b0;
                    n_rsp++;
                    id_log.push_back(int'(exp_id));
                    prod_log.push_back(int'(exp_prod));
                    $display("rsp #%0d id=%0d a=%0d b=%0d prod=%0d latency=%0d",
                             n_rsp, exp_id, exp_ma, exp_mb, rsp_prod, cyc - acc_cyc);
                end
            end
        end
        if (!rst_n) begin
            outstanding = 1'b0;
            model_ptr   = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (drop0) req0_valid = 1'b0;
        if (drop1) req1_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic rand_stim();
        rsp_ready = ($urandom_range(0, 3) != 0);
        if (!req0_valid) begin
            if ($urandom_range(0, 1) == 1) begin
                req0_valid = 1'b1;
                req0_a = N'($urandom_range(0, 15));
                req0_b = M'($urandom_range(0, 31));
            end
        end else if ($urandom_range(0, 7) == 0) begin
            req0_valid = 1'b0;
        end
        if (!req1_valid) begin
            if ($urandom_range(0, 1) == 1) begin
                req1_valid = 1'b1;
                req1_a = ($urandom_range(0, 3) == 0) ? N'(15) : N'($urandom_range(0, 15));
                req1_b = ($urandom_range(0, 3) == 0) ? M'(31) : M'($urandom_range(0, 31));
            end
        end else if ($urandom_range(0, 7) == 0) begin
            req1_valid = 1'b0;
        end
    endtask

    initial begin
        int exp_ids[4]   = '{0, 1, 0, 1};
        int exp_prods[4] = '{6, 63, 6, 63};
        int base;
        logic [N+M-1:0] held_prod;

        rst_n = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0;
        rsp_ready = 1'b0;
        s1_rst_n = 1'b0;
        s1_req0_valid = 1'b0; s1_req0_a = '0; s1_req0_b = '0;
        s1_req1_valid = 1'b0; s1_req1_a = '0; s1_req1_b = '0;
        s1_rsp_ready = 1'b0;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("reset_mult_a", int'(mult_a), 0);
        check_val("reset_mult_b", int'(mult_b), 0);
        check_val("reset_rsp_prod", int'(rsp_prod), 0);
        check_val("reset_rsp_id", int'(rsp_id), 0);
        check_val("reset_rsp_valid", int'(rsp_valid), 0);
        check_val("reset_busy", int'(busy), 0);
        @(negedge clk);

        // Single request 3*5
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 4'd3; req0_b = 5'd5;
        repeat (8) step();
        check_val("single_count", id_log.size(), 1);
        if (id_log.size() == 1) begin
            check_val("single_prod", prod_log[0], 15);
            check_val("single_id", id_log[0], 0);
        end

        // Maximum operands, then a zero operand
        prod_log.delete(); id_log.delete();
        req1_valid = 1'b1; req1_a = 4'd15; req1_b = 5'd31;
        repeat (8) step();
        req1_valid = 1'b1; req1_a = 4'd0; req1_b = 5'd31;
        repeat (8) step();
        check_val("max_count", prod_log.size(), 2);
        if (prod_log.size() == 2) begin
            check_val("max_prod", prod_log[0], 465);
            check_val("max_id", id_log[0], 1);
            check_val("zero_prod", prod_log[1], 0);
        end

        // Contention: both valid continuously
        prod_log.delete(); id_log.delete();
        auto_drop = 1'b0;
        req0_valid = 1'b1; req0_a = 4'd2; req0_b = 5'd3;
        req1_valid = 1'b1; req1_a = 4'd7; req1_b = 5'd9;
        repeat (4 * (ST + 2)) step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        auto_drop = 1'b1;
        repeat (8) step();
        check_val("contend_count_ge4", int'(id_log.size() >= 4), 1);
        if (id_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                check_val("contend_id", id_log[i], exp_ids[i]);
                check_val("contend_prod", prod_log[i], exp_prods[i]);
            end
        end

        // Backpressure in RESP
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 4'd4; req0_b = 5'd6;
        for (int i = 0; i < 10 && !rsp_valid; i++) step();
        check_val("bp_rsp_seen", int'(rsp_valid), 1);
        held_prod = rsp_prod;
        req1_valid = 1'b1; req1_a = 4'd9; req1_b = 5'd3;
        base = n_rsp;
        repeat (10) step();
        check_val("bp_prod_stable", int'(rsp_prod), int'(held_prod));
        check_val("bp_no_rsp", n_rsp, base);
        rsp_ready = 1'b1;
        step();
        check_val("bp_one_handshake", n_rsp, base + 1);
        repeat (8) step();

        // Reset during SETTLE of a 5*7 operation
        req0_valid = 1'b1; req0_a = 4'd5; req0_b = 5'd7;
        req1_valid = 1'b1; req1_a = 4'd5; req1_b = 5'd7;
        step();
        step();
        base = n_rsp;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_a = 4'd1; req0_b = 5'd2;
        req1_valid = 1'b1; req1_a = 4'd3; req1_b = 5'd4;
        #1;
        check_val("rst_mult_a", int'(mult_a), 0);
        check_val("rst_mult_b", int'(mult_b), 0);
        check_val("rst_rsp_prod", int'(rsp_prod), 0);
        check_val("rst_rsp_id", int'(rsp_id), 0);
        check_val("rst_rsp_valid", int'(rsp_valid), 0);
        check_val("rst_grant0", int'(req0_ready), 1);
        check_val("rst_no_grant1", int'(req1_ready), 0);
        step();
        check_val("rst_no_rsp", n_rsp, base);
        repeat (16) step();

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            rand_stim();
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        for (int i = 0; i < 30 && outstanding; i++) step();
        check_val("drain_done", int'(outstanding), 0);

        // SETTLE=1 instance: 9*17
        s1_rst_n = 1'b1;
        s1_rsp_ready = 1'b1;
        @(negedge clk);
        s1_req0_valid = 1'b1; s1_req0_a = 4'd9; s1_req0_b = 5'd17;
        #1;
        check_val("s1_ready", int'(s1_req0_ready), 1);
        @(posedge clk);
        #1;
        s1_req0_valid = 1'b0;
        @(negedge clk);
        check_val("s1_settle_rsp_valid", int'(s1_rsp_valid), 0);
        check_val("s1_busy", int'(s1_busy), 1);
        @(negedge clk);
        check_val("s1_rsp_valid", int'(s1_rsp_valid), 1);
        check_val("s1_rsp_prod", int'(s1_rsp_prod), 153);
        check_val("s1_rsp_id", int'(s1_rsp_id), 0);
        $display("rsp s1 id=%0d prod=%0d", s1_rsp_id, s1_rsp_prod);
        @(negedge clk);
        check_val("s1_idle_busy", int'(s1_busy), 0);
        check_val("s1_idle_rsp_valid", int'(s1_rsp_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mult_share_ctrl.md
Name: mult_share_ctrl

Overview:
- Sequencer and arbiter that shares one combinational N x M array multiplier (mult_NMbit, built from RCA rows) between two requesters.
- Grants one requester per operation, round-robin, and latches that requester's operands onto the multiplier inputs.
- Waits a fixed number of settle cycles for the and2/RCA delay chain to resolve, captures the product, and returns it on a valid/ready response channel tagged with the requester ID.

Parameters:
N  4  width of operand A (multiplier A input)
M  5  width of operand B (multiplier B input)
SETTLE  3  clock cycles between applying operands and sampling mult_prod; legal range 1..15

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operands accepted this cycle
req0_a  input  N  requester 0 operand A
req0_b  input  M  requester 0 operand B
req1_valid  input  1  requester 1 has an operation
req1_ready  output  1  requester 1 operands accepted this cycle
req1_a  input  N  requester 1 operand A
req1_b  input  M  requester 1 operand B
mult_a  output  N  registered operand A to multiplier
mult_b  output  M  registered operand B to multiplier
mult_prod  input  N+M  multiplier product (combinational from mult_a/mult_b)
rsp_valid  output  1  response holds a product
rsp_ready  input  1  consumer accepts the response
rsp_prod  output  N+M  captured product
rsp_id  output  1  requester that issued this product
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: synchronous, active-low, sampled on the rising clk edge.
  - Reset values: state=IDLE, mult_a=0, mult_b=0, rsp_valid=0, rsp_prod=0, rsp_id=0, req0_ready=0, req1_ready=0, busy=0.
  - Round-robin pointer resets to 0, so requester 0 has priority on the first contest.
  - Reset asserted in any state aborts the operation in flight with no response, and clears all of the above on the same edge.
- FSM states: IDLE, SETTLE, RESP.
- IDLE:
  - Arbitration: if exactly one valid is high, grant it. If both are high, grant the requester the pointer favours; the pointer then flips to favour the other requester.
  - reqX_ready is combinational: high only in IDLE, for the granted requester only. A transfer is reqX_valid & reqX_ready.
  - On a transfer: mult_a/mult_b <= granted operands, latch grant ID, counter <= SETTLE-1, go to SETTLE.
  - With no valid request, stay in IDLE.
- SETTLE:
  - mult_a/mult_b are held stable.
  - Counter decrements each cycle.
  - When counter==0: rsp_prod <= mult_prod, rsp_id <= grant ID, rsp_valid <= 1, go to RESP.
  - Total from the accept edge to rsp_valid high is exactly SETTLE cycles.
- RESP:
  - rsp_valid, rsp_prod and rsp_id are held stable until rsp_valid & rsp_ready.
  - On that handshake edge: rsp_valid <= 0, go to IDLE. The next request is accepted one cycle later at the earliest (no overlap).
  - Back-to-back throughput is one product per SETTLE+2 cycles when rsp_ready is held high.
- Ready and response rules:
  - Both readies are low outside IDLE. A requester that deasserts valid before being granted loses nothing.
  - rsp_ready high outside RESP has no effect.
- Width rules:
  - The product is unsigned, N+M bits, with no truncation.
  - The controller does no arithmetic on the product; it passes mult_prod through unchanged.
- Operand stability: mult_a/mult_b change only on the accept edge. They keep the last operands in RESP and IDLE; they are not cleared.

Test Plan:
- Single request, N=4, M=5, SETTLE=3: req0_a=3, req0_b=5, rsp_ready=1 → req0_ready high in the accept cycle; rsp_valid rises exactly 3 cycles after accept; rsp_prod=15, rsp_id=0; busy low again 1 cycle after the handshake.
- Max operands: req1_a=15, req1_b=31 → rsp_prod=465 (9'h1D1), rsp_id=1. Also 0*31 → rsp_prod=0.
- Contention: req0 and req1 valid continuously from the cycle after reset, with (a,b)=(2,3) for req0 and (7,9) for req1 → responses alternate 6 (id 0), 63 (id 1), 6 (id 0), 63 (id 1). Never two consecutive grants to one requester while both are valid.
- Backpressure: rsp_ready=0 for 10 cycles in RESP → rsp_valid, rsp_prod and rsp_id stay constant; no reqX_ready pulses; mult_a/mult_b unchanged. Release of rsp_ready → exactly one handshake, then IDLE.
- Reset mid-operation: drop rst_n for 1 cycle during SETTLE of a 5*7 operation → no response is emitted. All outputs hold reset values, and the next contest grants requester 0.
- SETTLE=1 regression → rsp_valid high one cycle after accept, with the correct product (e.g. 9*17=153).
